bus_fifo_responder: RTL and testbench

- Responder end of the single-cycle write/read strobe bus; the bus initiator drives `write`, `write_data` and `read`.
- Each accepted write pushes `write_data` into an internal FIFO.
- Each read pops the FIFO head into a registered `read_data`.
- Sits as the DUT behind the bus interface. Exposes occupancy and sticky error status for checkers and formal properties.

---
 rtl/bus_fifo_responder.sv | 102 ++++++++++
 tb/tb_bus_fifo_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_responder.sv
// Responder end of the single-cycle write/read strobe bus: writes push into a
// small FIFO, reads pop the head into a registered read_data, with sticky error flags.
`timescale 1ns/1ps

module bus_fifo_responder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [31:0]      write_data,
    input  logic             read,
    output logic [31:0]      read_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
        $error("bus_fifo_responder: DEPTH must be a power of two and >= 2");
    end
    if (CNT_W != $clog2(DEPTH) + 1) begin : g_badCntW
        $error("bus_fifo_responder: CNT_W is derived from DEPTH and must not be overridden");
    end

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_readData;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_isEmpty;
    logic             w_isFull;
    logic             w_doPop;
    logic             w_doPush;

    assign w_isEmpty = (r_count == '0);
    assign w_isFull  = (r_count == CNT_W'(DEPTH));
    assign w_doPop   = read && !w_isEmpty;
    // A pop in the same cycle frees a slot, so a write against a full FIFO still lands.
    assign w_doPush  = write && (!w_isFull || read);

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_readData  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (read) begin
                r_readData <= w_doPop ? r_mem[r_rdPtr] : '0;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (read && w_isEmpty) begin
                r_underflow <= 1'b1;
            end
            if (write && !w_doPush) begin
                r_overflow <= 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign read_data = r_readData;
    assign count     = r_count;
    assign empty     = w_isEmpty;
    assign full      = w_isFull;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    aCountBound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= CNT_W'(DEPTH));

    aPtrCount: assert property (@(posedge clk) disable iff (!rst_n)
        w_isFull ? (r_wrPtr == r_rdPtr)
                 : (r_count[PTR_W-1:0] == PTR_W'(r_wrPtr - r_rdPtr)));

endmodule

// File: tb/tb_bus_fifo_responder.sv
// Directed-vector bench for bus_fifo_responder (DEPTH=4) with hand-computed
// expected values; every comparison goes through checkOutput.
`timescale 1ns/1ps

module tb_bus_fifo_responder;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    bus_fifo_responder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .write_data (write_data),
        .read       (read),
        .read_data  (read_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive strobes, pass one rising edge, settle 1ns, release strobes.
    task automatic applyStimulus(input logic w, input logic [31:0] wd, input logic r);
        write      = w;
        write_data = wd;
        read       = r;
        @(posedge clk);
        #1;
        write      = 1'b0;
        write_data = '0;
        read       = 1'b0;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        write      = 1'b0;
        write_data = '0;
        read       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_read_data", read_data, 32'h0);
        checkOutput("rst_count",     32'(count), 32'd0);
        checkOutput("rst_empty",     32'(empty), 32'd1);
        checkOutput("rst_full",      32'(full), 32'd0);
        checkOutput("rst_overflow",  32'(overflow), 32'd0);
        checkOutput("rst_underflow", 32'(underflow), 32'd0);
        rst_n = 1'b1;

        // Ordering
        applyStimulus(1'b1, 32'h11111111, 1'b0);
        applyStimulus(1'b1, 32'h22222222, 1'b0);
        applyStimulus(1'b1, 32'h33333333, 1'b0);
        checkOutput("ord_count3", 32'(count), 32'd3);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ord_rd0", read_data, 32'h11111111);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ord_rd1", read_data, 32'h22222222);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("ord_rd2", read_data, 32'h33333333);
        checkOutput("ord_count0", 32'(count), 32'd0);
        checkOutput("ord_empty",  32'(empty), 32'd1);
        checkOutput("ord_noUnder", 32'(underflow), 32'd0);

        // Full and overflow
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0);
        checkOutput("full_full",   32'(full), 32'd1);
        checkOutput("full_count",  32'(count), 32'd4);
        checkOutput("full_noOvf",  32'(overflow), 32'd0);
        applyStimulus(1'b1, 32'hA4, 1'b0);
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("drain_%0d", i), read_data, 32'hA0 + 32'(i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        checkOutput("ovf_sticky",  32'(overflow), 32'd1);

        // Read+write while full
        pulseReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hD0 + 32'(i), 1'b0);
        applyStimulus(1'b1, 32'hB0, 1'b1);
        checkOutput("rwFull_data",  read_data, 32'hD0);
        checkOutput("rwFull_count", 32'(count), 32'd4);
        checkOutput("rwFull_noOvf", 32'(overflow), 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rwFull_rd1", read_data, 32'hD1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rwFull_rd2", read_data, 32'hD2);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rwFull_rd3", read_data, 32'hD3);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rwFull_rdB0", read_data, 32'hB0);
        checkOutput("rwFull_empty", 32'(empty), 32'd1);

        // Read+write while empty: underflow, no bypass
        applyStimulus(1'b1, 32'hC0, 1'b1);
        checkOutput("rwEmpty_data",  read_data, 32'h0);
        checkOutput("rwEmpty_under", 32'(underflow), 32'd1);
        checkOutput("rwEmpty_count", 32'(count), 32'd1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("rwEmpty_rdC0", read_data, 32'hC0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("hold_data", read_data, 32'hC0);

        // Wrap-around with pairs of writes then pairs of reads
        for (int p = 0; p < 5; p++) begin
            applyStimulus(1'b1, 32'h100 + 32'(2 * p), 1'b0);
            applyStimulus(1'b1, 32'h101 + 32'(2 * p), 1'b0);
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("wrap_%0d_a", p), read_data, 32'h100 + 32'(2 * p));
            applyStimulus(1'b0, '0, 1'b1);
            checkOutput($sformatf("wrap_%0d_b", p), read_data, 32'h101 + 32'(2 * p));
        end
        checkOutput("wrap_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream with count=3 and overflow=1
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hE0 + 32'(i), 1'b0);
        applyStimulus(1'b1, 32'hE4, 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("pre_count", 32'(count), 32'd3);
        checkOutput("pre_ovf",   32'(overflow), 32'd1);
        checkOutput("pre_data",  read_data, 32'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_ovf",   32'(overflow), 32'd0);
        checkOutput("async_under", 32'(underflow), 32'd0);
        checkOutput("async_empty", 32'(empty), 32'd1);
        checkOutput("async_data",  read_data, 32'h0);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_data",  read_data, 32'h0);
        checkOutput("post_under", 32'(underflow), 32'd1);
        checkOutput("post_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
